// File: rtl/dunc16_sequencer.sv
// DUNC16 control sequencer: HALT plus FETCH/EXECUTE major cycles of four phases,
// decoding register-load strobes and memory requests from state, IR and AN.
module dunc16_sequencer (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       RUN,
  input  logic [3:0] IR,
  input  logic       AN,
  input  logic       AZ,
  input  logic       MEM_RDY,
  output logic       T0,
  output logic       T1,
  output logic       T2,
  output logic       T3,
  output logic       FETCH,
  output logic       EXECUTE,
  output logic       EN_MA,
  output logic       EN_MD,
  output logic       EN_PC,
  output logic       EN_AC,
  output logic       EN_IR,
  output logic       EN_LINK,
  output logic       MA_SEL,
  output logic       PC_SEL,
  output logic       AC_SEL,
  output logic       MEM_RD,
  output logic       MEM_WR,
  output logic       HALTED
);

  typedef enum logic [3:0] {
    S_HALT, S_F0, S_F1, S_F2, S_F3, S_E0, S_E1, S_E2, S_E3
  } state_e;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0, OP_STA = 4'h1, OP_ADD = 4'h2, OP_BAN = 4'h3,
    OP_JMP = 4'h4, OP_BL  = 4'h5, OP_HLT = 4'hF
  } op_e;

  state_e state_q, state_d;
  logic   mem_op;
  logic   unused_az;

  // AZ is part of the datapath interface but no current opcode branches on it.
  assign unused_az = AZ;
  assign mem_op    = (IR == OP_LDA) || (IR == OP_ADD) || (IR == OP_STA);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_HALT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALT:  if (RUN) state_d = S_F0;
      S_F0:    state_d = S_F1;
      S_F1:    if (MEM_RDY) state_d = S_F2;
      S_F2:    state_d = S_F3;
      S_F3:    state_d = S_E0;
      S_E0:    state_d = (IR == OP_HLT) ? S_HALT : S_E1;
      S_E1:    if (MEM_RDY || !mem_op) state_d = S_E2;
      S_E2:    state_d = S_E3;
      S_E3:    state_d = S_F0;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    HALTED  = 1'b0;
    T0      = 1'b0;
    T1      = 1'b0;
    T2      = 1'b0;
    T3      = 1'b0;
    FETCH   = 1'b0;
    EXECUTE = 1'b0;
    EN_MA   = 1'b0;
    EN_MD   = 1'b0;
    EN_PC   = 1'b0;
    EN_AC   = 1'b0;
    EN_IR   = 1'b0;
    EN_LINK = 1'b0;
    MA_SEL  = 1'b0;
    PC_SEL  = 1'b0;
    AC_SEL  = 1'b0;
    MEM_RD  = 1'b0;
    MEM_WR  = 1'b0;
    case (state_q)
      S_HALT: HALTED = 1'b1;
      S_F0: begin
        FETCH = 1'b1; T0 = 1'b1;
        EN_MA = 1'b1;
      end
      S_F1: begin
        FETCH = 1'b1; T1 = 1'b1;
        MEM_RD = 1'b1;
      end
      S_F2: begin
        FETCH = 1'b1; T2 = 1'b1;
        EN_MD = 1'b1; EN_PC = 1'b1;
      end
      S_F3: begin
        FETCH = 1'b1; T3 = 1'b1;
        EN_IR = 1'b1; EN_MA = 1'b1; MA_SEL = 1'b1;
      end
      S_E0: begin
        EXECUTE = 1'b1; T0 = 1'b1;
        if ((IR == OP_JMP) || ((IR == OP_BAN) && AN)) begin
          EN_PC  = 1'b1;
          PC_SEL = 1'b1;
        end
        if (IR == OP_BL) EN_LINK = 1'b1;
      end
      S_E1: begin
        EXECUTE = 1'b1; T1 = 1'b1;
        MEM_RD  = (IR == OP_LDA) || (IR == OP_ADD);
        MEM_WR  = (IR == OP_STA);
        if (IR == OP_BL) begin
          EN_PC  = 1'b1;
          PC_SEL = 1'b1;
        end
      end
      S_E2: begin
        EXECUTE = 1'b1; T2 = 1'b1;
        EN_MD   = (IR == OP_LDA) || (IR == OP_ADD);
      end
      S_E3: begin
        EXECUTE = 1'b1; T3 = 1'b1;
        EN_AC   = (IR == OP_LDA) || (IR == OP_ADD);
        AC_SEL  = (IR == OP_ADD);
      end
      default: HALTED = 1'b0;
    endcase
  end

endmodule
